// File: rtl/adc_trig_pkg.sv
// Shared types and helpers for the ADC edge trigger engine.
// Contents: trigger state enum, word geometry constants, and saturating
// 8-bit add/subtract used to derive the hysteresis arming threshold.
package adc_trig_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLDOFF  = 2'd1,
    WAIT_ARM = 2'd2,
    ARMED    = 2'd3
  } trig_state_t;

  localparam int SAMPLES_PER_WORD = 8;
  localparam int SUBWORD_W        = 3;

  // a + b, clamped at 255
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // a - b, clamped at 0
  function automatic logic [7:0] sat_sub8(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? (a - b) : 8'h00;
  endfunction

endpackage

// File: rtl/adc_trig_scan.sv
// In-word crossing scan: walks samples oldest to newest, finds the first fire
// after the trigger is armed. Purely combinational (zero latency), no flow control.
// Ports: start_armed - word begins in ARMED; arm/fire - per-sample qualifiers;
//        fire_hit/fire_idx - first qualifying crossing; end_armed - armed at word end.
module adc_trig_scan
  import adc_trig_pkg::*;
(
  input  logic                        start_armed,
  input  logic [SAMPLES_PER_WORD-1:0] arm,
  input  logic [SAMPLES_PER_WORD-1:0] fire,
  output logic                        fire_hit,
  output logic [SUBWORD_W-1:0]        fire_idx,
  output logic                        end_armed
);

  always_comb begin
    logic armed_v;
    armed_v  = start_armed;
    fire_hit = 1'b0;
    fire_idx = '0;
    for (int i = 0; i < SAMPLES_PER_WORD; i++) begin
      if (!fire_hit) begin
        // Fire is tested before arm so a sample that arms cannot also fire
        // on its own index; once a fire is found the rest of the word is ignored.
        if (armed_v && fire[i]) begin
          fire_hit = 1'b1;
          fire_idx = SUBWORD_W'(i);
        end else if (arm[i]) begin
          armed_v = 1'b1;
        end
      end
    end
    end_armed = armed_v;
  end

endmodule

// File: rtl/adc_edge_trigger.sv
// Level/edge trigger with hysteresis and holdoff, forwarding the ADC word stream.
// Latency: 2 cycles (S1 compare register, S2 scan/state/output register).
// No backpressure: one word accepted every clock; trigger is aligned to its word.
// Ports: adc_bus_in/adc_in_valid/adc_eof_in - packed sample stream in (sample 0 oldest);
//        trig_* - trigger configuration; adc_bus/adc_data_valid/adc_eof - delayed stream;
//        trigger_in/trigger_sub_word - crossing pulse and sample index;
//        trig_armed/trig_count - status.
module adc_edge_trigger
  import adc_trig_pkg::*;
#(
  parameter int SAMPLE_W     = 8,
  parameter int WORD_SAMPLES = 8,
  parameter int HOLDOFF_W    = 16
) (
  input  logic                             adc_data_clk,
  input  logic                             adc_reset,
  input  logic [SAMPLE_W*WORD_SAMPLES-1:0] adc_bus_in,
  input  logic                             adc_in_valid,
  input  logic                             adc_eof_in,
  input  logic                             trig_enable,
  input  logic                             trig_edge,
  input  logic [7:0]                       trig_level,
  input  logic [7:0]                       trig_hyst,
  input  logic [HOLDOFF_W-1:0]             trig_holdoff,
  output logic [SAMPLE_W*WORD_SAMPLES-1:0] adc_bus,
  output logic                             adc_data_valid,
  output logic                             adc_eof,
  output logic                             trigger_in,
  output logic [SUBWORD_W-1:0]             trigger_sub_word,
  output logic                             trig_armed,
  output logic [15:0]                      trig_count
);

  localparam int BUS_W = SAMPLE_W * WORD_SAMPLES;

  // ---------------------------------------------------------------------------
  // S1: per-sample threshold compare, registered together with the word and
  // the configuration it was evaluated against.
  // ---------------------------------------------------------------------------
  logic [7:0]                  arm_th;
  logic [SAMPLES_PER_WORD-1:0] arm_c;
  logic [SAMPLES_PER_WORD-1:0] fire_c;

  // Rising arms well below the level, falling arms well above it.
  always_comb begin
    arm_th = trig_edge ? sat_add8(trig_level, trig_hyst)
                       : sat_sub8(trig_level, trig_hyst);
  end

  for (genvar i = 0; i < SAMPLES_PER_WORD; i++) begin : g_cmp
    logic [SAMPLE_W-1:0] smp;
    assign smp       = adc_bus_in[i*SAMPLE_W +: SAMPLE_W];
    assign arm_c[i]  = trig_edge ? (smp >= arm_th)     : (smp <= arm_th);
    assign fire_c[i] = trig_edge ? (smp <= trig_level) : (smp >= trig_level);
  end

  logic [BUS_W-1:0]            s1_bus;
  logic                        s1_vld;
  logic                        s1_eof;
  logic                        s1_en;
  logic [HOLDOFF_W-1:0]        s1_holdoff;
  logic [SAMPLES_PER_WORD-1:0] s1_arm;
  logic [SAMPLES_PER_WORD-1:0] s1_fire;

  always_ff @(posedge adc_data_clk or posedge adc_reset) begin
    if (adc_reset) begin
      s1_bus     <= '0;
      s1_vld     <= 1'b0;
      s1_eof     <= 1'b0;
      s1_en      <= 1'b0;
      s1_holdoff <= '0;
      s1_arm     <= '0;
      s1_fire    <= '0;
    end else begin
      s1_bus     <= adc_bus_in;
      s1_vld     <= adc_in_valid;
      s1_eof     <= adc_eof_in;
      s1_en      <= trig_enable;
      s1_holdoff <= trig_holdoff;
      s1_arm     <= arm_c;
      s1_fire    <= fire_c;
    end
  end

  // ---------------------------------------------------------------------------
  // S2: scan, state machine, output registers.
  // ---------------------------------------------------------------------------
  trig_state_t          state;
  trig_state_t          state_nx;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic [HOLDOFF_W-1:0] hold_nx;
  logic                 trig_nx;
  logic [SUBWORD_W-1:0] sub_nx;
  logic [15:0]          count_nx;

  logic                 scan_hit;
  logic [SUBWORD_W-1:0] scan_idx;
  logic                 scan_end_armed;

  adc_trig_scan u_scan (
    .start_armed (state == ARMED),
    .arm         (s1_arm),
    .fire        (s1_fire),
    .fire_hit    (scan_hit),
    .fire_idx    (scan_idx),
    .end_armed   (scan_end_armed)
  );

  always_comb begin
    state_nx = state;
    hold_nx  = hold_cnt;
    trig_nx  = 1'b0;
    sub_nx   = trigger_sub_word;
    count_nx = trig_count;

    // The enable travels with its word, so words already accepted while
    // enabled still deliver their trigger after the enable drops.
    if (!s1_en) begin
      state_nx = IDLE;
      hold_nx  = '0;
    end else if (s1_vld) begin
      unique case (state)
        IDLE: begin
          // The enabling word itself is not scanned.
          state_nx = WAIT_ARM;
        end
        HOLDOFF: begin
          hold_nx = hold_cnt - HOLDOFF_W'(1);
          if (hold_cnt <= HOLDOFF_W'(1)) begin
            state_nx = WAIT_ARM;
          end
        end
        WAIT_ARM, ARMED: begin
          if (scan_hit) begin
            trig_nx  = 1'b1;
            sub_nx   = scan_idx;
            count_nx = trig_count + 16'd1;
            if (s1_holdoff == '0) begin
              state_nx = WAIT_ARM;
              hold_nx  = '0;
            end else begin
              state_nx = HOLDOFF;
              hold_nx  = s1_holdoff;
            end
          end else if (scan_end_armed) begin
            state_nx = ARMED;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge adc_data_clk or posedge adc_reset) begin
    if (adc_reset) begin
      state            <= IDLE;
      hold_cnt         <= '0;
      trigger_in       <= 1'b0;
      trigger_sub_word <= '0;
      trig_count       <= '0;
      adc_bus          <= '0;
      adc_data_valid   <= 1'b0;
      adc_eof          <= 1'b0;
    end else begin
      state            <= state_nx;
      hold_cnt         <= hold_nx;
      trigger_in       <= trig_nx;
      trigger_sub_word <= sub_nx;
      trig_count       <= count_nx;
      adc_bus          <= s1_bus;
      adc_data_valid   <= s1_vld;
      adc_eof          <= s1_eof;
    end
  end

  assign trig_armed = (state == ARMED);

endmodule

// File: tb/tb_adc_edge_trigger.sv
// Self-checking bench for adc_edge_trigger: directed table, reset/enable
// corner sequences, then randomized words against a behavioural model.
module tb_adc_edge_trigger;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] bus_in;
  logic        in_vld, eof_in, en, edge_sel;
  logic [7:0]  level, hyst;
  logic [15:0] holdoff;

  logic [63:0] adc_bus;
  logic        adc_data_valid, adc_eof, trigger_in, trig_armed;
  logic [2:0]  trigger_sub_word;
  logic [15:0] trig_count;

  adc_edge_trigger dut (
    .adc_data_clk     (clk),
    .adc_reset        (rst),
    .adc_bus_in       (bus_in),
    .adc_in_valid     (in_vld),
    .adc_eof_in       (eof_in),
    .trig_enable      (en),
    .trig_edge        (edge_sel),
    .trig_level       (level),
    .trig_hyst        (hyst),
    .trig_holdoff     (holdoff),
    .adc_bus          (adc_bus),
    .adc_data_valid   (adc_data_valid),
    .adc_eof          (adc_eof),
    .trigger_in       (trigger_in),
    .trigger_sub_word (trigger_sub_word),
    .trig_armed       (trig_armed),
    .trig_count       (trig_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] word;
    logic        vld;
    logic        eof;
    logic        en;
    logic        edge_sel;
    logic [7:0]  level;
    logic [7:0]  hyst;
    logic [15:0] hold;
  } in_t;

  typedef struct packed {
    logic [63:0] bus;
    logic        vld;
    logic        eof;
    logic        trig;
    logic [2:0]  sub;
    logic        armed;
    logic [15:0] count;
  } out_t;

  typedef struct {
    in_t         i;
    logic        has;
    logic        t;
    logic [2:0]  s;
    logic        a;
    logic [15:0] c;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: 0 idle, 1 holdoff, 2 waiting to arm, 3 armed
  int          m_state;
  int          m_cnt;
  logic [15:0] m_count;
  logic [2:0]  m_sub;

  out_t        exp_prev;
  vec_t        hand_prev;
  string       hand_name;

  function automatic out_t got_now();
    return {adc_bus, adc_data_valid, adc_eof, trigger_in, trigger_sub_word,
            trig_armed, trig_count};
  endfunction

  task automatic model_reset();
    m_state     = 0;
    m_cnt       = 0;
    m_count     = '0;
    m_sub       = '0;
    exp_prev    = '0;
    hand_prev.has = 1'b0;
  endtask

  function automatic out_t model_step(in_t v);
    out_t e;
    int   th, s, first_arm, hit;
    e      = '0;
    e.bus  = v.word;
    e.vld  = v.vld;
    e.eof  = v.eof;
    if (!v.en) begin
      m_state = 0;
      m_cnt   = 0;
    end else if (v.vld) begin
      if (m_state == 0) begin
        m_state = 2;
      end else if (m_state == 1) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_state = 2;
      end else begin
        if (v.edge_sel) begin
          th = int'(v.level) + int'(v.hyst);
          if (th > 255) th = 255;
        end else begin
          th = int'(v.level) - int'(v.hyst);
          if (th < 0) th = 0;
        end
        // Index at which arming happened: -1 if the word starts armed, 8 if never.
        first_arm = (m_state == 3) ? -1 : 8;
        if (m_state != 3) begin
          for (int i = 7; i >= 0; i--) begin
            s = int'(v.word[8*i +: 8]);
            if (v.edge_sel ? (s >= th) : (s <= th)) first_arm = i;
          end
        end
        hit = -1;
        for (int j = 7; j > first_arm; j--) begin
          s = int'(v.word[8*j +: 8]);
          if (v.edge_sel ? (s <= int'(v.level)) : (s >= int'(v.level))) hit = j;
        end
        if (hit >= 0) begin
          e.trig  = 1'b1;
          m_sub   = 3'(hit);
          m_count = m_count + 16'd1;
          if (v.hold == 16'd0) begin
            m_state = 2;
          end else begin
            m_state = 1;
            m_cnt   = int'(v.hold);
          end
        end else if (first_arm < 8) begin
          m_state = 3;
        end
      end
    end
    e.sub   = m_sub;
    e.armed = (m_state == 3);
    e.count = m_count;
    return e;
  endfunction

  // Drive one word, advance one clock, then compare the word applied one call
  // earlier (which has now reached the outputs) against model and table.
  task automatic apply(input vec_t v, input string name);
    out_t e, got;
    bus_in   = v.i.word;
    in_vld   = v.i.vld;
    eof_in   = v.i.eof;
    en       = v.i.en;
    edge_sel = v.i.edge_sel;
    level    = v.i.level;
    hyst     = v.i.hyst;
    holdoff  = v.i.hold;
    e = model_step(v.i);
    @(posedge clk);
    #1;
    got = got_now();
    nvec++;
    if (got !== exp_prev) begin
      nerr++;
      $display("FAIL model %s: got %h want %h", hand_name, got, exp_prev);
    end
    if (hand_prev.has) begin
      nvec++;
      if ({trigger_in, trigger_sub_word, trig_armed, trig_count} !==
          {hand_prev.t, hand_prev.s, hand_prev.a, hand_prev.c}) begin
        nerr++;
        $display("FAIL table %s: got trig=%0b sub=%0d armed=%0b count=%0d want trig=%0b sub=%0d armed=%0b count=%0d",
                 hand_name, trigger_in, trigger_sub_word, trig_armed, trig_count,
                 hand_prev.t, hand_prev.s, hand_prev.a, hand_prev.c);
      end
    end
    exp_prev  = e;
    hand_prev = v;
    hand_name = name;
  endtask

  task automatic check_zero(input string name);
    nvec++;
    if (got_now() !== '0) begin
      nerr++;
      $display("FAIL %s: got %h want all zero", name, got_now());
    end
  endtask

  function automatic vec_t mk(logic [63:0] w, logic vld, logic eof, logic en_i,
                              logic edg, logic [7:0] lv, logic [7:0] hy,
                              logic [15:0] ho, logic t, logic [2:0] s,
                              logic a, logic [15:0] c);
    vec_t v;
    v.i   = '{word: w, vld: vld, eof: eof, en: en_i, edge_sel: edg,
              level: lv, hyst: hy, hold: ho};
    v.has = 1'b1;
    v.t   = t;
    v.s   = s;
    v.a   = a;
    v.c   = c;
    return v;
  endfunction

  localparam logic [63:0] SQ = 64'h20202020_A0A0A0A0;

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   c;

    rst = 1'b1; bus_in = '0; in_vld = 0; eof_in = 0; en = 0; edge_sel = 0;
    level = '0; hyst = '0; holdoff = '0;
    hand_prev.has = 1'b0;
    hand_name = "reset";
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    rst = 1'b0;
    model_reset();

    // word, vld, eof, en, edge, level, hyst, holdoff | trig, sub, armed, count
    tbl.push_back(mk(64'h60606060_60606060, 1, 0, 1, 0, 8'h80, 8'h10, 0, 0, 0, 0, 0));
    tbl.push_back(mk(64'h90909090_90757060, 1, 0, 1, 0, 8'h80, 8'h10, 0, 1, 3, 0, 1));
    tbl.push_back(mk(64'h60606060_60606060, 1, 0, 1, 0, 8'h80, 8'h10, 0, 0, 3, 1, 1));
    tbl.push_back(mk(64'h81818181_81817070, 1, 1, 1, 0, 8'h80, 8'h10, 0, 1, 2, 0, 2));
    tbl.push_back(mk(64'h3F504444_44444444, 1, 0, 1, 1, 8'h40, 8'h08, 0, 1, 7, 0, 3));
    tbl.push_back(mk(64'h06060606_06060601, 1, 0, 1, 0, 8'h05, 8'h10, 0, 0, 7, 0, 3));
    tbl.push_back(mk(64'h06060606_06060600, 1, 0, 1, 0, 8'h05, 8'h10, 0, 1, 1, 0, 4));
    // Square wave with holdoff 3: arm, fire on word 0, fire again on 5 and 10.
    tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 0, 1, 1, 4));
    tbl.push_back(mk(SQ, 1, 1, 1, 0, 8'h80, 8'h10, 3, 1, 0, 0, 5));
    tbl.push_back(mk(SQ, 0, 0, 1, 0, 8'h80, 8'h10, 3, 0, 0, 0, 5));
    for (int k = 0; k < 2; k++) begin
      repeat (3) tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 0, 0, 0, 16'(5 + k)));
      tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 0, 0, 1, 16'(5 + k)));
      tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 1, 0, 0, 16'(6 + k)));
    end
    // Disable while armed, then re-enable: one word to leave IDLE, one to arm.
    repeat (3) tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 0, 0, 0, 7));
    tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 0, 0, 1, 7));
    tbl.push_back(mk(SQ, 1, 0, 0, 0, 8'h80, 8'h10, 3, 0, 0, 0, 7));
    tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 0, 0, 0, 7));
    tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 3, 0, 0, 1, 7));
    // Trigger into a long holdoff, ready for an asynchronous reset.
    tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 5, 1, 0, 0, 8));
    tbl.push_back(mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 5, 0, 0, 0, 8));

    foreach (tbl[n]) apply(tbl[n], $sformatf("tbl%0d", n));

    // Asynchronous reset in the middle of holdoff, away from any clock edge.
    bus_in = SQ; in_vld = 0;
    #2;
    rst = 1'b1;
    #1;
    check_zero("async_reset_midholdoff");
    @(posedge clk);
    #1;
    check_zero("reset_held");
    rst = 1'b0;
    model_reset();
    hand_name = "post_reset";
    // After reset: IDLE, so first word only enables, second arms, third fires.
    v = mk(SQ, 1, 0, 1, 0, 8'h80, 8'h10, 0, 0, 0, 0, 0);
    apply(v, "rst_w0");
    v.a = 1;
    apply(v, "rst_w1");
    v.t = 1; v.a = 0; v.c = 1;
    apply(v, "rst_w2");

    // Randomized stream against the model.
    v.has = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) begin
        v.i.edge_sel = 1'($urandom_range(0, 1));
        v.i.level    = 8'($urandom_range(0, 255));
        v.i.hyst     = 8'($urandom_range(0, 40));
        v.i.hold     = 16'($urandom_range(0, 4));
      end
      for (int k = 0; k < 8; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          c = int'($urandom_range(0, 255));
        end else begin
          c = int'(v.i.level) + int'($urandom_range(0, 80)) - 40;
          if (c < 0) c = 0;
          if (c > 255) c = 255;
        end
        v.i.word[8*k +: 8] = 8'(c);
      end
      v.i.vld = ($urandom_range(0, 99) < 85);
      v.i.eof = ($urandom_range(0, 9) == 0);
      v.i.en  = ($urandom_range(0, 99) < 97);
      apply(v, $sformatf("rand%0d", n));
    end

    // Flush the last word through to the outputs.
    v.i.vld = 1'b0;
    v.i.en  = 1'b1;
    apply(v, "flush");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
